// File: rtl/data_mem_sized.sv
`default_nettype none
//============================================================================
// Module   : data_mem_sized
// Brief    : Byte-addressed little-endian data memory for the MIPS datapath.
//            Byte/half/word loads and stores with sign or zero extension,
//            registered read data with a valid strobe, and fault reporting
//            for misaligned, out-of-range and reserved-size accesses.
//            After reset a clear sequence zeroes every word (Busy high).
// Options  : DATA_MEM_FORWARD_EN - a simultaneous store and load to the same
//            word returns the post-write word (write-first); otherwise the
//            load sees the pre-write contents (read-first).
// Revision : 1.0 - initial release
//============================================================================
module data_mem_sized #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  WriteEnable,
  input  logic                  MemRead,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  ReadValid,
  output logic                  Fault,
  output logic                  Busy
);

  localparam int                 c_IDX_W    = $clog2(DEPTH_WORDS);
  localparam int                 c_LANES    = DATA_WIDTH / 8;
  localparam logic [c_IDX_W-1:0] c_LAST_PTR = c_IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t                r_state;
  logic [c_IDX_W-1:0]    r_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic [c_IDX_W-1:0]    w_idx;
  logic [1:0]            w_lane;
  logic                  w_oor;
  logic                  w_misalign;
  logic                  w_bad_size;
  logic                  w_illegal;
  logic                  w_req;
  logic                  w_in_idle;
  logic                  w_store;
  logic                  w_load;
  logic [c_LANES-1:0]    w_be;
  logic [DATA_WIDTH-1:0] w_wbytes;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_src;
  logic [7:0]            w_sel_byte;
  logic [15:0]           w_sel_half;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_mem_we;
  logic [c_IDX_W-1:0]    w_mem_idx;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  assign w_idx  = Address[c_IDX_W+1:2];
  assign w_lane = Address[1:0];
  // Any address bit above the word index means the access is outside the array.
  assign w_oor  = |Address[ADDR_WIDTH-1:c_IDX_W+2];

  // Size decode: lane enables, replicated store data and alignment checks.
  always_comb begin
    w_be       = '0;
    w_wbytes   = WriteData;
    w_misalign = 1'b0;
    w_bad_size = 1'b0;
    case (Size)
      2'b00: begin
        w_be     = 4'b0001 << w_lane;
        w_wbytes = {4{WriteData[7:0]}};
      end
      2'b01: begin
        w_misalign = Address[0];
        w_be       = Address[1] ? 4'b1100 : 4'b0011;
        w_wbytes   = {2{WriteData[15:0]}};
      end
      2'b10: begin
        w_misalign = |w_lane;
        w_be       = 4'b1111;
      end
      default: w_bad_size = 1'b1;
    endcase
  end

  assign w_illegal = w_oor | w_misalign | w_bad_size;
  assign w_req     = WriteEnable | MemRead;
  assign w_in_idle = (r_state == S_IDLE) && !Reset;
  assign w_store   = w_in_idle & WriteEnable & ~w_illegal;
  assign w_load    = w_in_idle & MemRead & ~w_illegal;
  assign w_old     = r_mem[w_idx];

  // Lane merge: addressed lanes take the new bytes, the rest keep old contents.
  generate
    for (genvar l = 0; l < c_LANES; l++) begin : g_lane
      assign w_merged[8*l +: 8] = w_be[l] ? w_wbytes[8*l +: 8] : w_old[8*l +: 8];
    end
  endgenerate

  // Load source: both accesses share one address, so the words always match.
`ifdef DATA_MEM_FORWARD_EN
  assign w_src = WriteEnable ? w_merged : w_old;
`else
  assign w_src = w_old;
`endif

  // Right-align the selected lanes and extend according to Unsigned.
  always_comb begin
    w_sel_byte  = w_src[{w_lane, 3'b000} +: 8];
    w_sel_half  = w_lane[1] ? w_src[31:16] : w_src[15:0];
    w_load_data = w_src;
    case (Size)
      2'b00:   w_load_data = {{24{~Unsigned & w_sel_byte[7]}}, w_sel_byte};
      2'b01:   w_load_data = {{16{~Unsigned & w_sel_half[15]}}, w_sel_half};
      default: w_load_data = w_src;
    endcase
  end

  // Single write port shared between the clear sequence and stores.
  assign w_mem_we    = (r_state == S_CLEAR) | w_store;
  assign w_mem_idx   = (r_state == S_CLEAR) ? r_ptr : w_idx;
  assign w_mem_wdata = (r_state == S_CLEAR) ? '0 : w_merged;

  // Storage array; no reset, the clear sequence initialises it.
  always_ff @(posedge Clock) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
  end

  // Control FSM with registered outputs: clear sweep, then request service.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= S_CLEAR;
      r_ptr     <= '0;
      ReadData  <= '0;
      ReadValid <= 1'b0;
      Fault     <= 1'b0;
      Busy      <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          ReadValid <= 1'b0;
          Fault     <= 1'b0;
          r_ptr     <= r_ptr + c_IDX_W'(1);
          if (r_ptr == c_LAST_PTR) begin
            r_state <= S_IDLE;
            Busy    <= 1'b0;
          end
        end
        default: begin
          Busy      <= 1'b0;
          Fault     <= w_req & w_illegal;
          ReadValid <= w_load;
          if (w_load) ReadData <= w_load_data;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_sized.sv
`default_nettype none
//============================================================================
// Module   : tb_data_mem_sized
// Brief    : Self-checking bench for data_mem_sized with a byte-array model.
// Revision : 1.0 - initial release
//============================================================================
module tb_data_mem_sized;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        WriteEnable;
  logic        MemRead;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] ReadData;
  logic        ReadValid;
  logic        Fault;
  logic        Busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem_m [0:4095];
  logic [31:0] last_rd;

  data_mem_sized #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .ADDR_WIDTH(32)) dut (
    .Clock(Clock), .Reset(Reset), .Address(Address), .WriteData(WriteData),
    .WriteEnable(WriteEnable), .MemRead(MemRead), .Size(Size), .Unsigned(Unsigned),
    .ReadData(ReadData), .ReadValid(ReadValid), .Fault(Fault), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (byte array) ----------------
  function automatic bit m_legal(input logic [31:0] a, input logic [1:0] s);
    if (a >= 32'd4096) return 1'b0;
    if (s == 2'b11) return 1'b0;
    if (s == 2'b01 && (a % 2) != 0) return 1'b0;
    if (s == 2'b10 && (a % 4) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    int n = 1 << s;
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(mem_m[a + i]) << (8 * i));
    if (n < 4 && !u && mem_m[a + n - 1][7]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    int n = 1 << s;
    for (int i = 0; i < n; i++) mem_m[a + i] = d[8*i +: 8];
  endtask

  task automatic m_clear();
    for (int i = 0; i < 4096; i++) mem_m[i] = 8'h00;
  endtask

  // Drive one request for one cycle; returns observed outputs and model predictions.
  task automatic drive(input logic we, input logic rd, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic of, output logic ov, output logic [31:0] od,
                       output logic ef, output logic ev, output logic [31:0] ed);
    bit ok = m_legal(a, s);
    logic [31:0] pre = 0;
    ef = (we || rd) && !ok;
    ev = rd && ok;
    if (ev) pre = m_load(a, s, u);
    if (we && ok) m_store(a, s, d);
`ifdef DATA_MEM_FORWARD_EN
    if (ev && we) pre = m_load(a, s, u);
`endif
    if (ev) last_rd = pre;
    ed = last_rd;
    WriteEnable = we; MemRead = rd; Size = s; Unsigned = u; Address = a; WriteData = d;
    @(posedge Clock); #1;
    of = Fault; ov = ReadValid; od = ReadData;
    WriteEnable = 0; MemRead = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int busy_cnt;
    bit saw_valid = 0;
    logic of, ov, ef, ev;
    logic [31:0] od, ed;
    Reset = 1; WriteEnable = 0; MemRead = 0; Size = 2; Unsigned = 1; Address = 0; WriteData = 0;
    @(posedge Clock); #1;
    n_tests++;
    if (Busy !== 1'b1 || ReadValid !== 1'b0 || Fault !== 1'b0 || ReadData !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b rv=%b f=%b rd=%h want 1 0 0 00000000",
               Busy, ReadValid, Fault, ReadData);
    end
    Reset = 0;
    m_clear();
    last_rd = 0;
    MemRead = 1; Address = 32'h10;  // must be ignored during the clear
    busy_cnt = 1;
    while (Busy === 1'b1 && busy_cnt < 3000) begin
      @(posedge Clock); #1;
      if (ReadValid === 1'b1) saw_valid = 1;
      if (Busy === 1'b1) busy_cnt++;
    end
    MemRead = 0;
    n_tests++;
    if (busy_cnt != 1024) begin
      n_fail++;
      $display("FAIL clear_length: got %0d busy cycles want 1024", busy_cnt);
    end
    n_tests++;
    if (saw_valid) begin
      n_fail++;
      $display("FAIL clear_ignores_load: got ReadValid=1 during clear want 0");
    end
    drive(0, 1, 2, 1, 32'h10, 0, of, ov, od, ef, ev, ed);
    n_tests++;
    if (ov !== 1'b1 || od !== 32'h0 || of !== 1'b0) begin
      n_fail++;
      $display("FAIL load_after_clear: got rv=%b rd=%h f=%b want 1 00000000 0", ov, od, of);
    end
  endtask

  task automatic test_byte_lanes();
    logic of, ov, ef, ev;
    logic [31:0] od, ed;
    logic [31:0] want [4];
    want[0] = 32'hEF; want[1] = 32'hBE; want[2] = 32'hAD; want[3] = 32'hDE;
    drive(1, 0, 2, 0, 32'h20, 32'hDEADBEEF, of, ov, od, ef, ev, ed);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 1, 32'h20 + i, 0, of, ov, od, ef, ev, ed);
      n_tests++;
      if (ov !== 1'b1 || od !== want[i]) begin
        n_fail++;
        $display("FAIL byte_load_u[%0d]: got rv=%b rd=%h want 1 %h", i, ov, od, want[i]);
      end
    end
    drive(0, 1, 0, 0, 32'h23, 0, of, ov, od, ef, ev, ed);
    n_tests++;
    if (ov !== 1'b1 || od !== 32'hFFFFFFDE) begin
      n_fail++;
      $display("FAIL byte_load_s: got rv=%b rd=%h want 1 ffffffde", ov, od);
    end
  endtask

  task automatic test_half();
    logic of, ov, ef, ev;
    logic [31:0] od, ed;
    drive(1, 0, 2, 0, 32'h40, 32'h11223344, of, ov, od, ef, ev, ed);
    drive(1, 0, 1, 0, 32'h42, 32'h5555AAAA, of, ov, od, ef, ev, ed);
    drive(0, 1, 2, 0, 32'h40, 0, of, ov, od, ef, ev, ed);
    n_tests++;
    if (ov !== 1'b1 || od !== 32'hAAAA3344) begin
      n_fail++;
      $display("FAIL half_store_merge: got rv=%b rd=%h want 1 aaaa3344", ov, od);
    end
    drive(0, 1, 1, 0, 32'h42, 0, of, ov, od, ef, ev, ed);
    n_tests++;
    if (ov !== 1'b1 || od !== 32'hFFFFAAAA) begin
      n_fail++;
      $display("FAIL half_load_s: got rv=%b rd=%h want 1 ffffaaaa", ov, od);
    end
    drive(0, 1, 1, 1, 32'h40, 0, of, ov, od, ef, ev, ed);
    n_tests++;
    if (ov !== 1'b1 || od !== 32'h00003344) begin
      n_fail++;
      $display("FAIL half_load_u: got rv=%b rd=%h want 1 00003344", ov, od);
    end
  endtask

  task automatic test_faults();
    logic of, ov, ef, ev;
    logic [31:0] od, ed;
    logic [31:0] held;
    held = last_rd;
    drive(0, 1, 2, 0, 32'h41, 0, of, ov, od, ef, ev, ed);
    n_tests++;
    if (of !== 1'b1 || ov !== 1'b0 || od !== held) begin
      n_fail++;
      $display("FAIL fault_word_misalign: got f=%b rv=%b rd=%h want 1 0 %h", of, ov, od, held);
    end
    drive(1, 0, 1, 0, 32'h43, 32'h0000BBBB, of, ov, od, ef, ev, ed);
    n_tests++;
    if (of !== 1'b1 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_half_misalign: got f=%b rv=%b want 1 0", of, ov);
    end
    drive(1, 0, 3, 0, 32'h40, 32'hCAFECAFE, of, ov, od, ef, ev, ed);
    n_tests++;
    if (of !== 1'b1 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_reserved_size: got f=%b rv=%b want 1 0", of, ov);
    end
    drive(0, 1, 2, 0, 32'h1000, 0, of, ov, od, ef, ev, ed);
    n_tests++;
    if (of !== 1'b1 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_out_of_range: got f=%b rv=%b want 1 0", of, ov);
    end
    drive(0, 1, 2, 0, 32'h40, 0, of, ov, od, ef, ev, ed);
    n_tests++;
    if (of !== 1'b0 || ov !== 1'b1 || od !== 32'hAAAA3344) begin
      n_fail++;
      $display("FAIL fault_mem_unchanged: got f=%b rv=%b rd=%h want 0 1 aaaa3344", of, ov, od);
    end
  endtask

  task automatic test_collision();
    logic of, ov, ef, ev;
    logic [31:0] od, ed, want;
`ifdef DATA_MEM_FORWARD_EN
    want = 32'hFFFFFFFF;
`else
    want = 32'h01010101;
`endif
    drive(1, 0, 2, 0, 32'h80, 32'h01010101, of, ov, od, ef, ev, ed);
    drive(1, 1, 2, 0, 32'h80, 32'hFFFFFFFF, of, ov, od, ef, ev, ed);
    n_tests++;
    if (ov !== 1'b1 || od !== want) begin
      n_fail++;
      $display("FAIL collision_load: got rv=%b rd=%h want 1 %h", ov, od, want);
    end
    drive(0, 1, 2, 0, 32'h80, 0, of, ov, od, ef, ev, ed);
    n_tests++;
    if (ov !== 1'b1 || od !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL collision_store: got rv=%b rd=%h want 1 ffffffff", ov, od);
    end
  endtask

  task automatic test_random();
    logic of, ov, ef, ev;
    logic [31:0] od, ed, a, d;
    logic we, rd, u;
    logic [1:0] s;
    for (int i = 0; i < 300; i++) begin
      a  = $urandom_range(0, 255);          // small window so loads hit stored data
      if ($urandom_range(0, 15) == 0) a = a | 32'h1000 | ($urandom & 32'hFFFF_0000);
      s  = 2'($urandom_range(0, 3) == 3 ? ($urandom_range(0, 7) == 0 ? 3 : 2) : $urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) a = (s == 2'd1) ? (a & ~32'h1) : ((s == 2'd2) ? (a & ~32'h3) : a);
      u  = 1'($urandom_range(0, 1));
      we = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 3) != 0);
      d  = $urandom;
      drive(we, rd, s, u, a, d, of, ov, od, ef, ev, ed);
      n_tests++;
      if (of !== ef || ov !== ev || od !== ed) begin
        n_fail++;
        $display("FAIL random[%0d] a=%h s=%0d we=%b rd=%b u=%b: got f=%b rv=%b rd=%h want f=%b rv=%b rd=%h",
                 i, a, s, we, rd, u, of, ov, od, ef, ev, ed);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [4];
    for (int i = 0; i < 4; i++) want[i] = m_load(32'h100 + 4 * i, 2, 0);
    for (int i = 0; i < 4; i++) begin
      WriteEnable = 0; MemRead = 1; Size = 2; Unsigned = 0; Address = 32'h100 + 4 * i;
      @(posedge Clock); #1;
      n_tests++;
      if (ReadValid !== 1'b1 || ReadData !== want[i]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got rv=%b rd=%h want 1 %h", i, ReadValid, ReadData, want[i]);
      end
    end
    MemRead = 0;
    last_rd = want[3];
  endtask

  task automatic test_mid_reset();
    int waited = 0;
    logic of, ov, ef, ev;
    logic [31:0] od, ed;
    drive(1, 0, 2, 0, 32'h200, 32'h12345678, of, ov, od, ef, ev, ed);
    drive(1, 0, 0, 0, 32'h305, 32'h000000A5, of, ov, od, ef, ev, ed);
    drive(1, 0, 1, 0, 32'h40A, 32'h0000BEEF, of, ov, od, ef, ev, ed);
    Reset = 1; MemRead = 1; Size = 2; Address = 32'h200;
    @(posedge Clock); #1;
    n_tests++;
    if (Busy !== 1'b1 || ReadValid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b rv=%b want 1 0", Busy, ReadValid);
    end
    Reset = 0; MemRead = 0;
    m_clear();
    last_rd = 0;
    while (Busy === 1'b1 && waited < 3000) begin
      @(posedge Clock); #1;
      waited++;
    end
    n_tests++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_clear_done: got busy=%b want 0", Busy);
    end
    drive(0, 1, 2, 0, 32'h200, 0, of, ov, od, ef, ev, ed);
    n_tests++;
    if (ov !== 1'b1 || od !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_word: got rv=%b rd=%h want 1 00000000", ov, od);
    end
    drive(0, 1, 0, 1, 32'h305, 0, of, ov, od, ef, ev, ed);
    n_tests++;
    if (ov !== 1'b1 || od !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_byte: got rv=%b rd=%h want 1 00000000", ov, od);
    end
    drive(0, 1, 1, 1, 32'h40A, 0, of, ov, od, ef, ev, ed);
    n_tests++;
    if (ov !== 1'b1 || od !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_half: got rv=%b rd=%h want 1 00000000", ov, od);
    end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_half();
    test_faults();
    test_collision();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_sized.md
Name: data_mem_sized

Overview:
- Parametrised successor to the single-cycle 32-bit data memory; used as the data memory in the MIPS datapath.
- Byte-addressed and little-endian, with byte, halfword and word loads and stores, and sign or zero extension on loads.
- Reads are registered, with a valid strobe. Alignment and range faults are reported.
- After reset, a clear sequence zeroes the whole array, so simulations start deterministic.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be 32.
- DEPTH_WORDS, 1024, number of words; must be a power of two.
- ADDR_WIDTH, 32, byte address width.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Address  input  ADDR_WIDTH  byte address.
- WriteData  input  DATA_WIDTH  store data; the LSBs are used for byte and halfword stores.
- WriteEnable  input  1  store request.
- MemRead  input  1  load request.
- Size  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- Unsigned  input  1  1 = zero-extend a load; 0 = sign-extend it.
- ReadData  output  DATA_WIDTH  registered load result.
- ReadValid  output  1  one-cycle pulse; ReadData is valid in that cycle.
- Fault  output  1  registered; a misaligned, out-of-range or reserved-Size access was attempted.
- Busy  output  1  high while the clear sequence runs.

Behaviour:
- Clock and reset: single clock domain, Clock. Reset is synchronous, active-high, and sampled on the rising edge of Clock.
- Reset values: ReadData = 0, ReadValid = 0, Fault = 0, Busy = 1, FSM = CLEAR, clear pointer = 0.
- FSM state CLEAR: writes 0 to word[ptr] every cycle and increments ptr.
  - When ptr == DEPTH_WORDS-1, the FSM goes to IDLE on that edge.
  - Busy drops in the first IDLE cycle. The clear takes exactly DEPTH_WORDS cycles.
  - Requests during CLEAR are ignored: no write, ReadValid = 0, Fault = 0.
- FSM state IDLE: serves requests. Reset asserted in any state returns the FSM to CLEAR with ptr = 0, restarting the clear.
- Address decode: word index = Address[log2(DEPTH_WORDS)+1:2]; byte lane = Address[1:0].
- Out of range: any Address bit above log2(DEPTH_WORDS)+1 is set.
- Misaligned: half access with Address[0] = 1, or word access with Address[1:0] != 0.
- Illegal access: out of range, misaligned, or Size = 11.
  - The access is dropped: no write and no ReadValid.
  - Fault = 1 in the next cycle; otherwise Fault = 0 each cycle.
- Store (WriteEnable = 1, legal access): at the edge, write only the addressed lanes.
  - Byte: lane = Address[1:0], data = WriteData[7:0].
  - Half: lanes {A1,0} and {A1,1}, data = WriteData[15:0].
  - Word: all four lanes.
  - Lanes that are not addressed keep their previous value.
- Load (MemRead = 1, WriteEnable = 0, legal access):
  - ReadData and ReadValid = 1 appear one cycle after the request (latency 1).
  - The selected byte or half is right-aligned, then extended according to Unsigned.
- Both WriteEnable = 1 and MemRead = 1 in the same cycle: the store is performed. The load is also answered, with data defined by the optional feature.
- ReadData holds its last value when ReadValid = 0.
- Back-to-back loads sustain one result per cycle.

Optional Feature:
- Macro DATA_MEM_FORWARD_EN.
- Defined: a simultaneous store and load to the same word returns the post-write merged word, then lane selection and extension (write-first).
- Undefined: the load returns the pre-write contents (read-first).
- Accesses to different words are unaffected in both cases.

Test Plan:
- Reset for 1 cycle, then release. Required: Busy = 1 for exactly 1024 cycles, then 0. A load from 0x10 then returns 0x00000000 with ReadValid one cycle later.
- Word store of 0xDEADBEEF at 0x20, then byte loads at 0x20–0x23 with Unsigned = 1. Required: 0xEF, 0xBE, 0xAD, 0xDE. A signed byte load at 0x23 returns 0xFFFFFFDE.
- Word at 0x40 = 0x11223344, then a half store of 0xAAAA at 0x42. Required: a word load returns 0xAAAA3344. A signed half load at 0x42 returns 0xFFFFAAAA.
- Word load at 0x41, half store at 0x43, and a load at 0x1000 (beyond 1024 words). Required: Fault = 1 the next cycle each time, ReadValid = 0, and memory unchanged.
- Word at 0x80 = 0x01010101, then store 0xFFFFFFFF and load at 0x80 in the same cycle. Required: ReadData = 0xFFFFFFFF with DATA_MEM_FORWARD_EN defined, 0x01010101 without it.
- Reset asserted mid-stream after 3 stores. Required: Busy = 1 and ReadValid = 0. After the clear completes, all stored addresses read 0.
